// File: rtl/tally_ctrl.sv
// Tally counter controller: button edge detect, IDLE/RUN/HOLD mode FSM, wrap/saturate count.
// One-cycle latency from button edge to outputs; no backpressure, button edges outside RUN are dropped.
module tally_ctrl #(
  parameter int WIDTH = 7,
  parameter int MAX   = 99,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_lvl,
  input  logic             dec_lvl,
  input  logic             ss_lvl,
  input  logic             clr_lvl,
  output logic [WIDTH-1:0] times,
  output logic             running,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  logic   inc_prev, dec_prev, ss_prev, clr_prev;
  logic   inc_rise, dec_rise, ss_rise, clr_rise;

  assign inc_rise = inc_lvl & ~inc_prev;
  assign dec_rise = dec_lvl & ~dec_prev;
  assign ss_rise  = ss_lvl  & ~ss_prev;
  assign clr_rise = clr_lvl & ~clr_prev;

  assign at_max  = (times == MAX_V);
  assign at_zero = (times == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      times    <= '0;
      running  <= 1'b0;
      ovf      <= 1'b0;
      // Prev registers start high so a button held through reset is not an event.
      inc_prev <= 1'b1;
      dec_prev <= 1'b1;
      ss_prev  <= 1'b1;
      clr_prev <= 1'b1;
    end else begin
      inc_prev <= inc_lvl;
      dec_prev <= dec_lvl;
      ss_prev  <= ss_lvl;
      clr_prev <= clr_lvl;

      if (clr_rise) begin
        state   <= IDLE;
        running <= 1'b0;
        times   <= '0;
        ovf     <= 1'b0;
      end else if (ss_rise) begin
        case (state)
          IDLE, HOLD: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            state   <= HOLD;
            running <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end else if (state == RUN && (inc_rise != dec_rise)) begin
        if (inc_rise) begin
          if (times == MAX_V) begin
            ovf <= 1'b1;
            if (WRAP != 0) times <= '0;
          end else begin
            times <= times + ONE;
          end
        end else begin
          if (times == '0) begin
            ovf <= 1'b1;
            if (WRAP != 0) times <= MAX_V;
          end else begin
            times <= times - ONE;
          end
        end
      end
    end
  end

endmodule
